cache_bus_arbiter: RTL and testbench

- Shares one sram-like master port (toward the AXI bridge) between the instruction-cache miss port and the data-cache miss port.
- Allows one outstanding transaction at a time, with fixed data-over-instruction priority.
- A starvation counter forces an instruction grant after STARVE_LIMIT consecutive data grants taken while the instruction port was waiting.
- Sits between i_cache/d_cache and the AXI interface.

---
 rtl/cache_bus_pkg.sv | 31 +++
 rtl/cache_bus_arbiter_if.sv | 19 +
 rtl/cache_bus_arbiter_grant_sel.sv | 24 ++
 rtl/cache_bus_arbiter.sv | 108 ++++++++++
 tb/tb_cache_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_bus_pkg.sv
// Shared types for the cache miss-port arbiter: FSM states, owner select,
// sram-like size codes and the command payload muxed onto the master port.
package cache_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    WAIT = 2'b10
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [SIZE_W-1:0] BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] HALF = 2'd1;
  localparam logic [SIZE_W-1:0] WORD = 2'd2;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// One sram-like request/response channel. The requesting side uses the
// master modport; the side that accepts and answers uses slave.
interface cache_bus_arbiter_if;
  import cache_bus_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  modport master (output req, wr, size, addr, wdata,
                  input  rdata, addr_ok, data_ok);
  modport slave  (input  req, wr, size, addr, wdata,
                  output rdata, addr_ok, data_ok);
endinterface

// File: rtl/cache_bus_arbiter_grant_sel.sv
// Combinational grant selector: data wins ties unless the instruction port
// has already lost STARVE_LIMIT consecutive contested grants.
module bus_grant_sel
  import cache_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                 inst_req,
  input  logic                 data_req,
  input  logic [CNT_WIDTH-1:0] starve_cnt,
  output logic                 grant_valid,
  output owner_e               grant_owner
);

  always_comb begin
    grant_valid = inst_req | data_req;
    grant_owner = OWN_INST;
    if (data_req && !(inst_req && (starve_cnt == CNT_WIDTH'(STARVE_LIMIT)))) begin
      grant_owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates the i-cache and d-cache miss ports onto one sram-like master
// port, one outstanding transaction at a time.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_bus_arbiter_if.slave   inst,
  cache_bus_arbiter_if.slave   data,
  cache_bus_arbiter_if.master  m
);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;

  logic      grant_valid;
  owner_e    grant_owner;
  sram_cmd_t inst_cmd, data_cmd, own_cmd;
  logic      owner_req;
  logic      m_req_c, own_addr_ok_c, own_data_ok_c;

  bus_grant_sel #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_grant_sel (
    .inst_req    (inst.req),
    .data_req    (data.req),
    .starve_cnt  (starve_cnt_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign inst_cmd  = '{wr: inst.wr, size: inst.size, addr: inst.addr, wdata: inst.wdata};
  assign data_cmd  = '{wr: data.wr, size: data.size, addr: data.addr, wdata: data.wdata};
  assign own_cmd   = (owner_q == OWN_DATA) ? data_cmd : inst_cmd;
  assign owner_req = (owner_q == OWN_DATA) ? data.req : inst.req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    starve_cnt_d  = starve_cnt_q;
    m_req_c       = 1'b0;
    own_addr_ok_c = 1'b0;
    own_data_ok_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          state_d = ADDR;
          // Only a data win over a waiting instruction request extends the streak
          if ((grant_owner == OWN_DATA) && inst.req) begin
            if (starve_cnt_q != CNT_WIDTH'(STARVE_LIMIT)) begin
              starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            starve_cnt_d = '0;
          end
        end
      end
      ADDR: begin
        m_req_c = owner_req;
        if (!owner_req) begin
          state_d = IDLE;
        end else if (m.addr_ok) begin
          own_addr_ok_c = 1'b1;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        own_data_ok_c = m.data_ok;
        if (m.data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m.req    = m_req_c;
  assign m.wr     = own_cmd.wr;
  assign m.size   = own_cmd.size;
  assign m.addr   = own_cmd.addr;
  assign m.wdata  = own_cmd.wdata;

  assign inst.addr_ok = own_addr_ok_c & (owner_q == OWN_INST);
  assign data.addr_ok = own_addr_ok_c & (owner_q == OWN_DATA);
  assign inst.data_ok = own_data_ok_c & (owner_q == OWN_INST);
  assign data.data_ok = own_data_ok_c & (owner_q == OWN_DATA);
  assign inst.rdata   = m.rdata;
  assign data.rdata   = m.rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Randomized and directed bench for cache_bus_arbiter against a
// transaction-level reference model with a grant-history starvation rule.
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CNT_WIDTH    = 3;

  logic clk = 1'b0;
  logic rst;

  cache_bus_arbiter_if inst_if ();
  cache_bus_arbiter_if data_if ();
  cache_bus_arbiter_if m_if ();

  cache_bus_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if.slave),
    .data (data_if.slave),
    .m    (m_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a transaction is either absent, issued-but-not-accepted,
  // or accepted-awaiting-data. hist holds one entry per grant: 1 when data
  // won while inst was waiting, 0 otherwise.
  bit in_flight = 1'b0;
  bit accepted  = 1'b0;
  int own       = 0;
  int hist[$];
  bit saw_ok[2];
  int gnt_log[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int streak();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != 1) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic port_req(input int p);
    return (p == 0) ? inst_if.req : data_if.req;
  endfunction

  task automatic set_req(input int p, input logic r, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      inst_if.req = r; inst_if.wr = wr; inst_if.size = sz; inst_if.addr = a; inst_if.wdata = wd;
    end else begin
      data_if.req = r; data_if.wr = wr; data_if.size = sz; data_if.addr = a; data_if.wdata = wd;
    end
  endtask

  // Called at a falling edge with inputs already set; checks, clocks the model, returns at next falling edge.
  task automatic step();
    logic ireq, dreq, oreq, maok, mdok, exp_mreq;
    sram_cmd_t oc;
    #1;
    ireq = inst_if.req; dreq = data_if.req; maok = m_if.addr_ok; mdok = m_if.data_ok;
    oreq = (own == 1) ? dreq : ireq;
    oc   = (own == 1) ? '{data_if.wr, data_if.size, data_if.addr, data_if.wdata}
                      : '{inst_if.wr, inst_if.size, inst_if.addr, inst_if.wdata};
    exp_mreq = !rst && in_flight && !accepted && oreq;
    check_val("m_req", 32'(m_if.req), 32'(exp_mreq));
    if (exp_mreq) begin
      check_val("m_addr",  m_if.addr, oc.addr);
      check_val("m_wr",    32'(m_if.wr), 32'(oc.wr));
      check_val("m_size",  32'(m_if.size), 32'(oc.size));
      check_val("m_wdata", m_if.wdata, oc.wdata);
    end
    check_val("inst_addr_ok", 32'(inst_if.addr_ok), 32'(exp_mreq && own == 0 && maok));
    check_val("data_addr_ok", 32'(data_if.addr_ok), 32'(exp_mreq && own == 1 && maok));
    check_val("inst_data_ok", 32'(inst_if.data_ok), 32'(!rst && in_flight && accepted && own == 0 && mdok));
    check_val("data_data_ok", 32'(data_if.data_ok), 32'(!rst && in_flight && accepted && own == 1 && mdok));
    check_val("inst_rdata", inst_if.rdata, m_if.rdata);
    check_val("data_rdata", data_if.rdata, m_if.rdata);
    saw_ok[0] = inst_if.addr_ok;
    saw_ok[1] = data_if.addr_ok;
    if (inst_if.addr_ok) gnt_log.push_back(0);
    if (data_if.addr_ok) gnt_log.push_back(1);
    @(posedge clk);
    if (rst) begin
      in_flight = 1'b0; accepted = 1'b0; own = 0; hist.delete();
    end else if (!in_flight) begin
      if (ireq || dreq) begin
        if (ireq && dreq) own = (streak() >= STARVE_LIMIT) ? 0 : 1;
        else              own = dreq ? 1 : 0;
        hist.push_back((own == 1 && ireq) ? 1 : 0);
        if (hist.size() > 16) void'(hist.pop_front());
        in_flight = 1'b1; accepted = 1'b0;
      end
    end else if (!accepted) begin
      if (!oreq)     in_flight = 1'b0;
      else if (maok) accepted  = 1'b1;
    end else if (mdok) begin
      in_flight = 1'b0; accepted = 1'b0;
    end
    @(negedge clk);
  endtask

  // Zero-wait slave until everything outstanding has finished.
  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      if (!in_flight && !inst_if.req && !data_if.req) break;
      m_if.addr_ok = 1'b1; m_if.data_ok = 1'b1;
      step();
      for (int p = 0; p < 2; p++) if (saw_ok[p]) set_req(p, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
    end
    check_val("drain_done", 32'(in_flight || inst_if.req || data_if.req), 32'h0);
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0;
  endtask

  task automatic inst_read(input logic [31:0] a, input logic [31:0] rd);
    set_req(0, 1'b1, 1'b0, WORD, a, 32'h0);
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0;
    step();
    m_if.addr_ok = 1'b1;
    step();
    check_val("iread_accepted", 32'(saw_ok[0]), 32'h1);
    set_req(0, 1'b0, 1'b0, WORD, a, 32'h0);
    m_if.addr_ok = 1'b0;
    step();
    m_if.data_ok = 1'b1; m_if.rdata = rd;
    #1;
    check_val("iread_data_ok", 32'(inst_if.data_ok), 32'h1);
    check_val("iread_rdata", inst_if.rdata, rd);
    check_val("iread_dport_ok", 32'(data_if.data_ok), 32'h0);
    step();
    m_if.data_ok = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] exp_order [6];
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, BYTE, 32'h0, 32'h0);
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0; m_if.rdata = 32'h0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();

    inst_read(32'hBFC0_0000, 32'h3C08_0001);

    // Simultaneous requests: data wins, inst follows
    gnt_log.delete();
    set_req(0, 1'b1, 1'b0, WORD, 32'hBFC0_0004, 32'h0);
    set_req(1, 1'b1, 1'b1, WORD, 32'h0000_1000, 32'hDEAD_BEEF);
    drain();
    check_val("simul_n", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) begin
      check_val("simul_first", 32'(gnt_log[0]), 32'd1);
      check_val("simul_second", 32'(gnt_log[1]), 32'd0);
    end

    // Starvation: inst held, data re-requests back-to-back
    gnt_log.delete();
    set_req(0, 1'b1, 1'b0, WORD, 32'hBFC0_0100, 32'h0);
    set_req(1, 1'b1, 1'b0, WORD, 32'h0000_2000, 32'h0);
    m_if.addr_ok = 1'b1; m_if.data_ok = 1'b1;
    for (int c = 0; c < 24; c++) begin
      m_if.rdata = $urandom;
      step();
      if (saw_ok[0]) set_req(0, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
      if (saw_ok[1]) set_req(1, 1'b1, 1'b0, WORD, 32'h0000_2000 + 32'(4 * c), 32'h0);
    end
    set_req(1, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
    drain();
    exp_order = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
    check_val("starve_n", 32'(gnt_log.size() >= 6), 32'h1);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check_val($sformatf("starve_gnt%0d", i), 32'(gnt_log[i]), exp_order[i]);

    // Back-pressure: address held for 10 cycles without acceptance
    set_req(1, 1'b1, 1'b1, HALF, 32'h0000_3000, 32'h1234_5678);
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      check_val("bp_no_ok", 32'(saw_ok[0] || saw_ok[1]), 32'h0);
    end
    drain();

    // Stray data_ok while idle
    m_if.data_ok = 1'b1;
    for (int c = 0; c < 3; c++) step();
    m_if.data_ok = 1'b0;
    inst_read(32'hBFC0_0200, 32'hCAFE_F00D);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (port_req(p) && (saw_ok[p] || $urandom_range(0, 39) == 0))
          set_req(p, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
        if (!port_req(p) && $urandom_range(0, 2) == 0)
          set_req(p, 1'b1, (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0,
                  2'($urandom_range(0, 2)), $urandom, $urandom);
      end
      m_if.addr_ok = 1'($urandom_range(0, 1));
      m_if.data_ok = ($urandom_range(0, 2) == 0);
      m_if.rdata   = $urandom;
      step();
    end
    for (int p = 0; p < 2; p++) if (!saw_ok[p]) set_req(p, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
    drain();

    // Async reset while waiting for read data
    set_req(0, 1'b1, 1'b0, WORD, 32'hBFC0_0300, 32'h0);
    step();
    m_if.addr_ok = 1'b1;
    step();
    set_req(0, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'h0BAD_0BAD;
    #1;
    check_val("pre_rst_data_ok", 32'(inst_if.data_ok), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_data_ok", 32'(inst_if.data_ok), 32'h0);
    check_val("async_rst_m_req", 32'(m_if.req), 32'h0);
    in_flight = 1'b0; accepted = 1'b0; own = 0; hist.delete();
    @(negedge clk);
    m_if.data_ok = 1'b0;
    step();
    rst = 1'b0;
    step();
    inst_read(32'hBFC0_0400, 32'h2408_0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
